ram_key_scheduler: RTL
======================

# ram_key_scheduler

Runs the RC4 key-scheduling pass over the 256-entry S-array RAM after the identity-fill stage has written S[i] = i. For i = 0..255 it computes j = j + S[i] + key[i mod KEY_BYTES] and swaps S[i] with S[j] through a single-port synchronous RAM. It sits between the S-array initializer, which it follows in the top-level sequencer, and the PRGA/decrypt stage, which it releases through `finished`.

## Interface
- `RAM_WIDTH`, 8: data and address width; the RAM depth is 2^RAM_WIDTH.
- `KEY_BYTES`, 3: key length in bytes.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: level input. A rising edge (start high, previous-cycle sample low) requests one pass.
- `key` in KEY_BYTES*8: secret key. Key byte 0 = `key[KEY_BYTES*8-1 -: 8]`, so byte 0 is the most significant byte.
- `busy` out 1: pass in progress.
- `finished` out 1: one-cycle pulse at end of pass.
- `write_enable` out RAM_WIDTH-independent 1: RAM write strobe.
- `address` out RAM_WIDTH: RAM address.
- `ram_in` out RAM_WIDTH: RAM write data.
- `ram_out` in RAM_WIDTH: RAM read data. `ram_out` is valid two rising edges after the edge that registered `address`.

## Operation
- All outputs are registered. Reset values: `busy`=0, `finished`=0, `write_enable`=0, `address`=0, `ram_in`=0; internal `i`=0, `j`=0, state=IDLE.
- Start edge detection uses an internal registered copy of `start`. Start edges while `busy`=1 are ignored.
- States and transitions:
  - **IDLE**: on a start edge, clear i=0 and j=0, set `busy`=1, and go to ADDR_I.
  - **ADDR_I**: `address`=i, `write_enable`=0. Go to WAIT_I.
  - **WAIT_I**: at the end of the cycle, latch si = `ram_out` and set j = j + si + keybyte[i mod KEY_BYTES]. The sum is taken modulo 2^RAM_WIDTH, with the carry discarded. Go to ADDR_J.
  - **ADDR_J**: `address`=j. Go to WAIT_J.
  - **WAIT_J**: at the end of the cycle, latch sj = `ram_out`. Go to WRITE_I.
  - **WRITE_I**: `address`=i, `ram_in`=sj, `write_enable`=1. Go to WRITE_J.
  - **WRITE_J**: `address`=j, `ram_in`=si, `write_enable`=1.
    - If i=255, go to IDLE with `finished`=1 and `busy`=0.
    - Otherwise set i=i+1 and go to ADDR_I.
- `finished` is high for exactly one cycle, then returns to 0.
- i mod KEY_BYTES is tracked with a wrap counter (0..KEY_BYTES-1) that resets to 0 with i. No divider is used.
- When i==j, both writes carry the same value to the same address. The RAM contents are unchanged and this is legal.
- `key` is sampled every iteration. It must be held stable while `busy`=1.
- Reset mid-pass: the next edge returns to IDLE with all outputs at reset values. RAM is left partially swapped. The next pass requires the initializer to run again.

## Timing
- Start edge registered at edge E: ADDR_I (i=0) is visible after E.
- Each iteration takes 6 cycles. WRITE_I is visible after E+4+6k; WRITE_J after E+5+6k.
- `finished`=1 is visible after edge E+1536, for one cycle.
- `write_enable` is high only in WRITE_I and WRITE_J.

## Configuration
- Macro: `RAM_KEY_SCHEDULER_SKIP_SELF_SWAP_EN`.
- **Defined:** in WAIT_I, if the newly computed j equals i, skip ADDR_J through WRITE_J and go directly to ADDR_I with i+1, or to IDLE with `finished` if i=255. That iteration takes 2 cycles and has no writes. Total pass length is data-dependent.
- **Undefined:** every iteration takes 6 cycles and issues two writes. A pass is always 1536 cycles.

## Test plan
- Identity S, `key`=24'h0A0B0C, start pulse:
  - First WRITE_I: `address`=0x00, `ram_in`=0x0A.
  - First WRITE_J: `address`=0x0A, `ram_in`=0x00.
- Identity S, `key`=24'h000000, macro undefined:
  - i=1 writes value 1 to address 1 twice.
  - i=2 writes S[2]=3 and S[3]=2.
  - `finished` pulses once at E+1536.
- Same stimulus with the macro defined:
  - No writes for i=0 or i=1.
  - First `write_enable` is at `address`=2 with `ram_in`=3.
  - `finished` arrives earlier than E+1536.
- Full pass with `key`=24'h4A7F11 compared against a software RC4 KSA model: the final 256 RAM bytes match exactly.
- A start edge mid-pass is ignored. `start` held high produces exactly one pass.
- `reset`=0 at i=100: the next cycle shows `busy`=0, `write_enable`=0, `address`=0. A new start edge restarts with i=0, j=0.

Source files
------------

// File: rtl/ram_key_scheduler.sv
// RC4 key-scheduling pass over a 256-entry single-port synchronous S-array RAM.
// Optional macro RAM_KEY_SCHEDULER_SKIP_SELF_SWAP_EN skips iterations where j == i.
module ram_key_scheduler #(
  parameter int unsigned RAM_WIDTH = 8,
  parameter int unsigned KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [KEY_BYTES*8-1:0] key,
  output logic                   busy,
  output logic                   finished,
  output logic                   write_enable,
  output logic [RAM_WIDTH-1:0]   address,
  output logic [RAM_WIDTH-1:0]   ram_in,
  input  logic [RAM_WIDTH-1:0]   ram_out
);

  localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [RAM_WIDTH-1:0] LAST_I = '1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_I,
    WAIT_I,
    ADDR_J,
    WAIT_J,
    WRITE_I,
    WRITE_J
  } state_t;

  state_t               state, state_d;
  logic [RAM_WIDTH-1:0] i, i_d;
  logic [RAM_WIDTH-1:0] j, j_d;
  logic [RAM_WIDTH-1:0] si, si_d;
  logic [KW-1:0]        kidx, kidx_d;
  logic                 start_q;
  logic                 busy_d, finished_d, write_enable_d;
  logic [RAM_WIDTH-1:0] address_d, ram_in_d;

  logic                 start_edge;
  logic [7:0]           key_byte;
  logic [RAM_WIDTH-1:0] j_sum;
  logic [RAM_WIDTH-1:0] i_inc;
  logic [KW-1:0]        kidx_inc;
  logic                 last_iter;

  assign start_edge = start & ~start_q;
  assign j_sum      = j + ram_out + RAM_WIDTH'(key_byte);
  assign i_inc      = i + RAM_WIDTH'(1);
  assign kidx_inc   = (kidx == KW'(KEY_BYTES - 1)) ? '0 : kidx + KW'(1);
  assign last_iter  = (i == LAST_I);

  // Key byte 0 is the most significant byte of key; kidx tracks i mod KEY_BYTES.
  always_comb begin
    key_byte = 8'h00;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kidx == KW'(b)) key_byte = key[(KEY_BYTES-1-b)*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      i            <= '0;
      j            <= '0;
      si           <= '0;
      kidx         <= '0;
      start_q      <= 1'b0;
      busy         <= 1'b0;
      finished     <= 1'b0;
      write_enable <= 1'b0;
      address      <= '0;
      ram_in       <= '0;
    end else begin
      state        <= state_d;
      i            <= i_d;
      j            <= j_d;
      si           <= si_d;
      kidx         <= kidx_d;
      start_q      <= start;
      busy         <= busy_d;
      finished     <= finished_d;
      write_enable <= write_enable_d;
      address      <= address_d;
      ram_in       <= ram_in_d;
    end
  end

  // Next state and next registered outputs; outputs reflect the state being entered.
  always_comb begin
    state_d        = state;
    i_d            = i;
    j_d            = j;
    si_d           = si;
    kidx_d         = kidx;
    busy_d         = busy;
    finished_d     = 1'b0;
    write_enable_d = 1'b0;
    address_d      = address;
    ram_in_d       = ram_in;

    case (state)
      IDLE: begin
        if (start_edge) begin
          i_d       = '0;
          j_d       = '0;
          kidx_d    = '0;
          busy_d    = 1'b1;
          address_d = '0;
          state_d   = ADDR_I;
        end
      end
      ADDR_I: state_d = WAIT_I;
      WAIT_I: begin
        si_d = ram_out;
        j_d  = j_sum;
`ifdef RAM_KEY_SCHEDULER_SKIP_SELF_SWAP_EN
        if (j_sum == i) begin
          if (last_iter) begin
            busy_d     = 1'b0;
            finished_d = 1'b1;
            address_d  = '0;
            state_d    = IDLE;
          end else begin
            i_d       = i_inc;
            kidx_d    = kidx_inc;
            address_d = i_inc;
            state_d   = ADDR_I;
          end
        end else begin
          address_d = j_sum;
          state_d   = ADDR_J;
        end
`else
        address_d = j_sum;
        state_d   = ADDR_J;
`endif
      end
      ADDR_J: state_d = WAIT_J;
      WAIT_J: begin
        ram_in_d       = ram_out;
        address_d      = i;
        write_enable_d = 1'b1;
        state_d        = WRITE_I;
      end
      WRITE_I: begin
        ram_in_d       = si;
        address_d      = j;
        write_enable_d = 1'b1;
        state_d        = WRITE_J;
      end
      WRITE_J: begin
        if (last_iter) begin
          busy_d     = 1'b0;
          finished_d = 1'b1;
          address_d  = '0;
          state_d    = IDLE;
        end else begin
          i_d       = i_inc;
          kidx_d    = kidx_inc;
          address_d = i_inc;
          state_d   = ADDR_I;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
